// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch slice.
//   INSTR_BYTES       bytes per instruction word (PC increment)
//   WORD_SHIFT        log2(INSTR_BYTES); low PC bits forced to zero on redirect
//   RESET_PC_DEFAULT  default fetch PC after reset
//   NOP_WORD          value held in cleared queue entries
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned WORD_SHIFT       = 2;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, the redirect source and decode.
//   pc_addr      byte address to instruction memory
//   mem_instr    word returned combinationally by memory for pc_addr
//   redirect     flush queue, restart fetch at redirect_pc
//   redirect_pc  new fetch PC (low two bits ignored)
//   instr, pc    head-of-queue word and its byte PC
//   valid        queue non-empty
//   ready        decode accepts the head this cycle
//   count        queue occupancy
// Modport master is the fetch unit; slave is the memory/decode/redirect side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] mem_instr;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] pc;
  logic              valid;
  logic              ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output pc_addr,
    input  mem_instr,
    input  redirect,
    input  redirect_pc,
    output instr,
    output pc,
    output valid,
    input  ready,
    output count
  );

  modport slave (
    input  pc_addr,
    output mem_instr,
    output redirect,
    output redirect_pc,
    input  instr,
    input  pc,
    input  valid,
    output ready,
    input  count
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch buffer of DEPTH {instr, pc} entries.
//   clk_i, rst_i    clock, asynchronous active-low reset
//   push_i          write {push_instr_i, push_pc_i} at tail
//   pop_i           retire head entry (caller guarantees non-empty)
//   flush_i         empty the queue, reset pointers; overrides push/pop
//   instr_o, pc_o   head entry (registered storage, combinational read)
//   valid_o         queue non-empty
//   full_o          occupancy equals DEPTH
//   count_o         occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          push_instr_i,
  input  logic [ADDR_W-1:0]          push_pc_i,
  output logic [DATA_W-1:0]          instr_o,
  output logic [ADDR_W-1:0]          pc_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PTR_W'(1);
      if (pop_i)  head_d = head_q + PTR_W'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= DATA_W'(NOP_WORD);
        pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_i && !flush_i) begin
        instr_q[tail_q] <= push_instr_i;
        pc_q[tail_q]    <= push_pc_i;
      end
    end
  end

  assign instr_o = instr_q[head_q];
  assign pc_o    = pc_q[head_q];
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, fetches one word per cycle from a
// combinational instruction memory into a prefetch queue, and hands words to decode
// over valid/ready. A redirect flushes the queue and restarts fetch at the new PC.
//   clk_i      clock
//   rst_i      asynchronous active-low reset
//   fetch_bus  memory, redirect and decode signals (master side)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input logic                clk_i,
  input logic                rst_i,
  instr_fetch_unit_if.master fetch_bus
);
  logic              push, pop, full;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Redirect overrides both sides; a full queue still accepts a word when the head leaves.
  always_comb begin
    pop  = fetch_bus.valid & fetch_bus.ready & ~fetch_bus.redirect;
    push = ~fetch_bus.redirect & (~full | pop);
    pc_d = pc_q;
    if (fetch_bus.redirect) begin
      pc_d = {fetch_bus.redirect_pc[ADDR_W-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign fetch_bus.pc_addr = pc_q;

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (fetch_bus.redirect),
    .push_instr_i (fetch_bus.mem_instr),
    .push_pc_i    (pc_q),
    .instr_o      (fetch_bus.instr),
    .pc_o         (fetch_bus.pc),
    .valid_o      (fetch_bus.valid),
    .full_o       (full),
    .count_o      (fetch_bus.count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus0 ();
  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus1 ();

  instr_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut0 (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .fetch_bus (bus0)
  );

  instr_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFF8)
  ) dut1 (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .fetch_bus (bus1)
  );

  // Memory model: word[k] = k + 1
  assign bus0.mem_instr   = (bus0.pc_addr >> 2) + 32'd1;
  assign bus1.mem_instr   = (bus1.pc_addr >> 2) + 32'd1;
  assign bus1.ready       = 1'b1;
  assign bus1.redirect    = 1'b0;
  assign bus1.redirect_pc = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_run(input logic [31:0] start_pc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start_pc + 32'(4 * i);
      e.instr = (e.pc >> 2) + 32'd1;
      sb_q.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    #1;
    rst_n                = 1'b0;
    bus0.ready           = rdy;
    bus0.redirect        = 1'b0;
    bus0.redirect_pc     = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: samples just before each rising edge, scores every accepted head word.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus0.valid && bus0.ready && !bus0.redirect) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got instr %h pc %h, no word expected",
                   bus0.instr, bus0.pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (bus0.instr !== e.instr || bus0.pc !== e.pc) begin
            n_err++;
            $display("FAIL pop_data: got instr %h pc %h expected instr %h pc %h",
                     bus0.instr, bus0.pc, e.instr, e.pc);
          end
        end
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus0.ready       = 1'b0;
    bus0.redirect    = 1'b0;
    bus0.redirect_pc = 32'h0;

    // 1: streaming with ready held high
    do_reset(1'b1);
    chk("rst_valid", 32'(bus0.valid), 32'd0);
    chk("rst_count", 32'(bus0.count), 32'd0);
    chk("rst_instr", bus0.instr, 32'd0);
    chk("rst_pc", bus0.pc, 32'd0);
    chk("rst_pc_addr", bus0.pc_addr, 32'd0);
    chk("rst_pc_addr1", bus1.pc_addr, 32'hFFFF_FFF8);
    expect_run(32'h0, 5);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_count", 32'(bus0.count), 32'd1);
      chk("t1_valid", 32'(bus0.valid), 32'd1);
      chk("t1_pc_addr", bus0.pc_addr, 32'(4 * k));
    end
    bus0.ready = 1'b0;
    step();
    chk("t1_drain", 32'(sb_q.size()), 32'd0);

    // 2: fill to DEPTH with ready low, then drain
    do_reset(1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t2_fill_count", 32'(bus0.count), 32'((k < 4) ? k : 4));
      chk("t2_fill_pc_addr", bus0.pc_addr, 32'(4 * ((k < 4) ? k : 4)));
    end
    expect_run(32'h0, 6);
    bus0.ready = 1'b1;
    for (int k = 7; k <= 12; k++) begin
      step();
      chk("t2_full_count", 32'(bus0.count), 32'd4);
      chk("t2_pc_addr", bus0.pc_addr, 32'(16 + 4 * (k - 6)));
    end
    chk("t2_drain", 32'(sb_q.size()), 32'd0);

    // 3: redirect while full, unaligned target
    bus0.redirect    = 1'b1;
    bus0.redirect_pc = 32'h43;
    step();
    chk("t3_count", 32'(bus0.count), 32'd0);
    chk("t3_valid", 32'(bus0.valid), 32'd0);
    chk("t3_pc_addr", bus0.pc_addr, 32'h40);
    bus0.redirect = 1'b0;
    bus0.ready    = 1'b0;
    step();
    chk("t3_valid2", 32'(bus0.valid), 32'd1);
    chk("t3_pc", bus0.pc, 32'h40);
    chk("t3_instr", bus0.instr, 32'd17);
    chk("t3_count2", 32'(bus0.count), 32'd1);

    // 4: redirect with ready high does not consume; held redirect, last target wins
    bus0.redirect    = 1'b1;
    bus0.ready       = 1'b1;
    bus0.redirect_pc = 32'h100;
    step();
    chk("t4_count", 32'(bus0.count), 32'd0);
    chk("t4_valid", 32'(bus0.valid), 32'd0);
    chk("t4_pc_addr", bus0.pc_addr, 32'h100);
    bus0.redirect_pc = 32'h203;
    step();
    chk("t4_count_held", 32'(bus0.count), 32'd0);
    chk("t4_pc_addr_last", bus0.pc_addr, 32'h200);
    bus0.redirect = 1'b0;
    bus0.ready    = 1'b0;
    step();
    chk("t4_valid2", 32'(bus0.valid), 32'd1);
    chk("t4_pc", bus0.pc, 32'h200);
    chk("t4_instr", bus0.instr, 32'h81);
    chk("t4_count2", 32'(bus0.count), 32'd1);
    chk("t4_drain", 32'(sb_q.size()), 32'd0);

    // 5: PC wrap on dut1; 6: mid-stream async reset on dut0
    do_reset(1'b0);
    step();
    chk("t5_pc0", bus1.pc, 32'hFFFF_FFF8);
    chk("t5_instr0", bus1.instr, 32'h3FFF_FFFF);
    chk("t6_count1", 32'(bus0.count), 32'd1);
    step();
    chk("t5_pc1", bus1.pc, 32'hFFFF_FFFC);
    chk("t5_instr1", bus1.instr, 32'h4000_0000);
    chk("t6_count2", 32'(bus0.count), 32'd2);
    step();
    chk("t5_pc2", bus1.pc, 32'h0000_0000);
    chk("t5_instr2", bus1.instr, 32'h1);
    chk("t5_count", 32'(bus1.count), 32'd1);
    chk("t6_count3", 32'(bus0.count), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(bus0.count), 32'd0);
    chk("t6_async_valid", 32'(bus0.valid), 32'd0);
    chk("t6_async_instr", bus0.instr, 32'd0);
    chk("t6_async_pc", bus0.pc, 32'd0);
    chk("t6_async_pc_addr", bus0.pc_addr, 32'd0);
    chk("t6_async_pc_addr1", bus1.pc_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    chk("t6_rel_count", 32'(bus0.count), 32'd0);
    step();
    chk("t6_restart_count", 32'(bus0.count), 32'd1);
    chk("t6_restart_pc", bus0.pc, 32'd0);
    chk("t6_restart_instr", bus0.instr, 32'd1);
    chk("t6_restart_pc_addr", bus0.pc_addr, 32'd4);
    chk("final_drain", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
